// File: rtl/sample_sequencer.sv
// sample_sequencer: paces the sensor and the 3-tap averager, then offers each
// average to the status process over valid/ready with sticky overrun detection.
module sample_sequencer #(
    parameter int SAMPLE_PERIOD = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int WINDOW        = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    output logic       sample_o,
    output logic       avg_en_o,
    input  logic [7:0] avg_data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       warm_o,
    output logic       overrun_o
);
    localparam int            FW          = $clog2(WINDOW + 1);
    localparam logic [15:0]   PERIOD_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FILL_FULL   = FW'(WINDOW);

    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, LATCH, WAIT} state_e;

    state_e        state_q, state_d;
    logic [15:0]   period_q, period_d;
    logic [7:0]    settle_q, settle_d;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    logic          sample_q, sample_d;
    logic          avg_en_q, avg_en_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          warm_q, warm_d;
    logic          overrun_q, overrun_d;
    logic          load;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        fill_d    = fill_q;
        sample_d  = sample_q;
        warm_d    = warm_q;
        avg_en_d  = 1'b0;
        period_d  = (state_q == IDLE || period_q == PERIOD_LAST) ? '0 : period_q + 16'd1;
        fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
        load      = (state_q == LATCH) && (fill_inc == FILL_FULL);
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    sample_d = ~sample_q;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d  = CAPTURE;
                    avg_en_d = 1'b1;
                end
            end
            CAPTURE: state_d = LATCH;
            LATCH: begin
                fill_d  = fill_inc;
                warm_d  = warm_q | load;
                state_d = WAIT;
            end
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    fill_d  = '0;
                    warm_d  = 1'b0;
                end else if (period_q == PERIOD_LAST) begin
                    sample_d = ~sample_q;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A load coinciding with a transfer keeps valid high and is not an overrun
        data_d    = load ? avg_data_i : data_q;
        valid_d   = load || (valid_q && !ready_i);
        overrun_d = overrun_q || (load && valid_q && !ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            period_q  <= '0;
            settle_q  <= '0;
            fill_q    <= '0;
            sample_q  <= 1'b0;
            avg_en_q  <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            warm_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            settle_q  <= settle_d;
            fill_q    <= fill_d;
            sample_q  <= sample_d;
            avg_en_q  <= avg_en_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            warm_q    <= warm_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_o  = sample_q;
    assign avg_en_o  = avg_en_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign warm_o    = warm_q;
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: drives sample_sequencer with an attached averager model and
// compares it against an edge-timed reference derived from the sampling schedule.
module tb_sample_sequencer;
    localparam int P = 8;
    localparam int S = 2;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [7:0] avg_data = 8'h00;
    logic       sample_o, avg_en_o, valid_o, warm_o, overrun_o;
    logic [7:0] data_o;
    int         errors = 0;
    int         checks = 0;
    int         rdq[$];

    sample_sequencer #(.SAMPLE_PERIOD(P), .SETTLE_CYCLES(S), .WINDOW(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .sample_o(sample_o),
        .avg_en_o(avg_en_o), .avg_data_i(avg_data), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .warm_o(warm_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Averager: each strobe shifts in the next sensor reading; result valid next cycle
    int tap0 = 0, tap1 = 0, tap2 = 0;
    always @(posedge clk) begin : averager
        int v;
        if (rst_i) begin
            tap0 = 0; tap1 = 0; tap2 = 0;
        end else if (avg_en_o) begin
            v = (rdq.size() > 0) ? rdq.pop_front() : int'($urandom_range(0, 200)) - 100;
            tap2 = tap1; tap1 = tap0; tap0 = v;
            avg_data <= 8'((tap0 + tap1 + tap2) / 3);
        end
    end

    // Reference: timing measured in edges from the most recent sample toggle
    bit         m_busy = 0;
    int         m_t = 0, m_n = 0, m_fill = 0;
    logic       m_sample = 0, m_avg_en = 0, m_valid = 0, m_warm = 0, m_ovr = 0;
    logic [7:0] m_data = 0;
    always @(posedge clk) begin : model
        bit ld;
        int k;
        ld = 0;
        if (rst_i) begin
            m_busy = 0; m_fill = 0; m_sample = 0; m_valid = 0; m_warm = 0; m_ovr = 0; m_data = 0;
        end else if (!m_busy) begin
            if (enable_i) begin m_sample = ~m_sample; m_t = m_n; m_busy = 1; end
        end else begin
            k = m_n - m_t;
            if (k == S + 2) begin
                m_fill = (m_fill < W) ? m_fill + 1 : W;
                if (m_fill == W) begin ld = 1; m_warm = 1; end
            end else if (k >= S + 3) begin
                if (!enable_i) begin m_busy = 0; m_fill = 0; m_warm = 0; end
                else if (k == P) begin m_sample = ~m_sample; m_t = m_n; end
            end
        end
        m_avg_en = !rst_i && m_busy && (m_n - m_t == S);
        if (!rst_i) begin
            if (ld) begin
                m_ovr = m_ovr | (m_valid & ~ready_i);
                m_data = avg_data;
                m_valid = 1;
            end else if (ready_i) m_valid = 0;
        end
        m_n++;
    end

    logic [12:0] dut_vec, mod_vec;
    assign dut_vec = {sample_o, avg_en_o, valid_o, warm_o, overrun_o, data_o};
    assign mod_vec = {m_sample, m_avg_en, m_valid, m_warm, m_ovr, m_data};

    task automatic reset_dut(input logic en, input logic rdy);
        rst_i = 1; enable_i = en; ready_i = rdy;
        @(negedge clk);
        @(negedge clk);
        rst_i = 0;
    endtask

    task automatic test_reset_timing();
        logic prev_s;
        logic [12:0] got, exp;
        logic [7:0] ed;
        rdq = {30, 33, 36, 39, 42, 45, 48};
        reset_dut(1, 1);
        checks++;
        if (dut_vec !== 13'h0) begin
            errors++; $display("FAIL reset_state: got %h expected 0000", dut_vec);
        end
        prev_s = sample_o;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            ed = (c < 21) ? 8'd0 : (c < 29) ? 8'd33 : 8'd36;
            got = {sample_o != prev_s, avg_en_o, valid_o, warm_o, overrun_o, data_o};
            exp = {c inside {1, 9, 17, 25}, c inside {3, 11, 19, 27}, c == 21 || c == 29, c >= 21, 1'b0, ed};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL timing cycle %0d: got %h expected %h", c, got, exp);
            end
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL timing_model cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
            prev_s = sample_o;
        end
    endtask

    task automatic test_overrun();
        ready_i = 0;
        for (int c = 31; c <= 58; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL overrun_model cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
            if (c == 36) begin
                checks++;
                if (overrun_o !== 1'b0) begin
                    errors++; $display("FAIL early_overrun: got %b expected 0", overrun_o);
                end
            end
            if (c == 44) begin
                checks++;
                if ({valid_o, data_o} !== {1'b1, 8'd39}) begin
                    errors++; $display("FAIL held_data: got %h expected 127", {valid_o, data_o});
                end
            end
            if (c == 45) begin
                checks++;
                if ({overrun_o, valid_o, data_o} !== {2'b11, 8'd42}) begin
                    errors++; $display("FAIL overwrite: got %h expected 32a", {overrun_o, valid_o, data_o});
                end
            end
            if (c == 50) ready_i = 1;
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL sticky_overrun: got %b expected 1", overrun_o);
        end
    endtask

    task automatic test_disable();
        rdq = {};
        reset_dut(1, 1);
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL disable_model cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
            if (c >= 4 && c <= 20) begin
                checks++;
                if ({sample_o, avg_en_o, warm_o, valid_o} !== 4'b1000) begin
                    errors++; $display("FAIL disabled cycle %0d: got %b expected 1000", c, {sample_o, avg_en_o, warm_o, valid_o});
                end
            end
            if (c >= 21) begin
                checks++;
                if ({valid_o, warm_o} !== {c == 41, c == 41}) begin
                    errors++; $display("FAIL rewarm cycle %0d: got %b expected %b", c, {valid_o, warm_o}, {c == 41, c == 41});
                end
            end
            if (c == 3) enable_i = 0;
            if (c == 20) enable_i = 1;
        end
    endtask

    task automatic test_reset_mid();
        rdq = {5, 6, 7};
        reset_dut(1, 0);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL midrst_model cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
        end
        checks++;
        if ({valid_o, overrun_o} !== 2'b11) begin
            errors++; $display("FAIL pending_before_reset: got %b expected 11", {valid_o, overrun_o});
        end
        rst_i = 1;
        @(negedge clk);
        checks++;
        if (dut_vec !== 13'h0) begin
            errors++; $display("FAIL mid_reset: got %h expected 0000", dut_vec);
        end
        rst_i = 0;
        @(negedge clk);
        checks++;
        if (avg_en_o !== 1'b0) begin
            errors++; $display("FAIL stale_strobe: got %b expected 0", avg_en_o);
        end
    endtask

    task automatic test_back_to_back();
        rdq = {10, 20, 30, 40};
        reset_dut(1, 0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL b2b_model cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
            if (c == 29) begin
                checks++;
                if ({valid_o, overrun_o, data_o} !== {2'b10, 8'd30}) begin
                    errors++; $display("FAIL coincide: got %h expected 21e", {valid_o, overrun_o, data_o});
                end
            end
            if (c == 30) begin
                checks++;
                if (valid_o !== 1'b0) begin
                    errors++; $display("FAIL after_transfer: got %b expected 0", valid_o);
                end
            end
            if (c == 28) ready_i = 1;
        end
    endtask

    task automatic test_random();
        rdq = {};
        reset_dut(1, 1);
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mod_vec) begin
                errors++; $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec, mod_vec);
            end
            if ($urandom_range(0, 39) == 0) enable_i = ~enable_i;
            ready_i = 1'($urandom_range(0, 1));
            rst_i = ($urandom_range(0, 299) == 0);
        end
    endtask

    initial begin
        test_reset_timing();
        test_overrun();
        test_disable();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
